// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the async_fifo write port
// among NREQ requesters, in bursts of up to BURST words per grant.
//
// Ports:
//   wclk, wrst_n   write-domain clock, async active-low reset
//   req_valid      per-requester word valid
//   req_data       per-requester word, requester k at [k*DSIZE +: DSIZE]
//   req_last       per-requester end-of-packet marker
//   req_ready      per-requester accept (combinational)
//   winc, wdata    registered FIFO write strobe and data
//   wfull, awfull  FIFO full / one-slot-left flags
//   grant_valid    a grant is held
//   grant_id       granted requester index
module fifo_wr_arbiter #(
    parameter int DSIZE = 32,
    parameter int NREQ  = 4,
    parameter int BURST = 4,
    localparam int IW   = $clog2(NREQ),
    localparam int BW   = $clog2(BURST + 1)
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    input  logic                  wfull,
    input  logic                  awfull,
    output logic                  grant_valid,
    output logic [IW-1:0]         grant_id
);

    typedef enum logic {ARB, GRANT} state_t;

    state_t           state, state_d;
    logic [IW-1:0]    rr_ptr, rr_ptr_d;
    logic [IW-1:0]    grant_id_d, pick_id, next_ptr;
    logic [BW-1:0]    beat_cnt, beat_cnt_d, beat_nxt;
    logic             grant_valid_d, winc_d;
    logic             pick_found, accept_ok, accepted;
    logic             cur_valid, cur_last;
    logic [DSIZE-1:0] wdata_d, cur_data;

    // A write already in flight into the last free slot blocks a new word.
    assign accept_ok = !wfull && !(awfull && winc);

    assign cur_valid = req_valid[grant_id];
    assign cur_last  = req_last[grant_id];
    assign cur_data  = req_data[int'(grant_id)*DSIZE +: DSIZE];
    assign accepted  = (state == GRANT) && cur_valid && accept_ok;
    assign beat_nxt  = beat_cnt + BW'(1);
    assign next_ptr  = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);

    always_comb begin
        req_ready = '0;
        if (state == GRANT && accept_ok) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Circular search from rr_ptr; scanning downward lets the nearest
    // valid index overwrite any farther one.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[(int'(rr_ptr) + i) % NREQ]) begin
                pick_found = 1'b1;
                pick_id    = IW'((int'(rr_ptr) + i) % NREQ);
            end
        end
    end

    always_comb begin
        state_d       = state;
        rr_ptr_d      = rr_ptr;
        grant_id_d    = grant_id;
        grant_valid_d = grant_valid;
        beat_cnt_d    = beat_cnt;
        winc_d        = accepted;
        wdata_d       = accepted ? cur_data : wdata;
        unique case (state)
            ARB: begin
                if (pick_found) begin
                    state_d       = GRANT;
                    grant_id_d    = pick_id;
                    grant_valid_d = 1'b1;
                    beat_cnt_d    = '0;
                end
            end
            GRANT: begin
                if (!cur_valid) begin
                    state_d       = ARB;
                    grant_valid_d = 1'b0;
                    rr_ptr_d      = next_ptr;
                end else if (accepted) begin
                    beat_cnt_d = beat_nxt;
                    if (cur_last || beat_nxt == BW'(BURST)) begin
                        state_d       = ARB;
                        grant_valid_d = 1'b0;
                        rr_ptr_d      = next_ptr;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state       <= ARB;
            rr_ptr      <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            beat_cnt    <= '0;
            winc        <= 1'b0;
            wdata       <= '0;
        end else begin
            state       <= state_d;
            rr_ptr      <= rr_ptr_d;
            grant_id    <= grant_id_d;
            grant_valid <= grant_valid_d;
            beat_cnt    <= beat_cnt_d;
            winc        <= winc_d;
            wdata       <= wdata_d;
        end
    end

    no_overflow: assert property (
        @(posedge wclk) disable iff (!wrst_n) !(winc && wfull));

endmodule
